// File: rtl/superh16_pkg.sv
// superh16_pkg: shared widths and the writeback entry type for the superh16 core.
package superh16_pkg;
    localparam int XLEN          = 64;
    localparam int PHYS_REG_BITS = 10;
    localparam int ISSUE_WIDTH   = 12;
    localparam int NUM_WB_SRC    = 16;

    typedef struct packed {
        logic [PHYS_REG_BITS-1:0] tag;
        logic [XLEN-1:0]          data;
    } wb_entry_t;
endpackage

// File: rtl/superh16_wb_fifo.sv
// superh16_wb_fifo: single-producer result FIFO; pointers carry an extra wrap bit
// so full and empty are told apart by the MSB.
module superh16_wb_fifo
    import superh16_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  wb_entry_t                din,
    output wb_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr, rd_ptr;
    wb_entry_t   mem [DEPTH];

    assign count = wr_ptr - rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !flush)
            mem[wr_ptr[AW-1:0]] <= din;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst)
            assert (!(push && full)) else $error("push while full");
    end
`endif
endmodule

// File: rtl/superh16_wb_arbiter.sv
// superh16_wb_arbiter: buffers producer results per source and drains up to
// NUM_WR of them per cycle, round-robin, onto registered regfile write ports.
module superh16_wb_arbiter
    import superh16_pkg::*;
#(
    parameter int NUM_SRC    = NUM_WB_SRC,
    parameter int NUM_WR     = ISSUE_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       flush,
    input  logic [NUM_SRC-1:0]                         src_valid,
    output logic [NUM_SRC-1:0]                         src_ready,
    input  logic [PHYS_REG_BITS-1:0]                   src_tag [NUM_SRC],
    input  logic [XLEN-1:0]                            src_data [NUM_SRC],
    output logic [NUM_WR-1:0]                          wr_en,
    output logic [PHYS_REG_BITS-1:0]                   wr_tag [NUM_WR],
    output logic [XLEN-1:0]                            wr_data [NUM_WR],
    output logic [$clog2(NUM_SRC*FIFO_DEPTH+1)-1:0]    occupancy,
    output logic [15:0]                                stall_cnt
);
    localparam int SW = $clog2(NUM_SRC);
    localparam int GW = $clog2(NUM_WR + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = $clog2(NUM_SRC*FIFO_DEPTH + 1);

    wb_entry_t            head [NUM_SRC];
    logic [CW-1:0]        count [NUM_SRC];
    logic [NUM_SRC-1:0]   full, empty, push, pop;
    logic [SW-1:0]        rr_ptr, rr_nxt;
    logic [SW-1:0]        gsrc [NUM_WR];
    logic [NUM_WR-1:0]    gv;
    logic [OW-1:0]        occ_nxt;

    assign src_ready = ~full;
    assign push      = src_valid & src_ready & {NUM_SRC{!flush}};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
        superh16_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (wb_entry_t'{src_tag[i], src_data[i]}),
            .head  (head[i]),
            .full  (full[i]),
            .empty (empty[i]),
            .count (count[i])
        );
    end

    // Cyclic scan from rr_ptr; the n-th non-empty head found goes to port n.
    always_comb begin
        logic [GW-1:0] n;
        logic [SW-1:0] idx;
        gv     = '0;
        pop    = '0;
        rr_nxt = rr_ptr;
        n      = '0;
        idx    = '0;
        for (int k = 0; k < NUM_WR; k++)
            gsrc[k] = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            idx = SW'((int'(rr_ptr) + s) % NUM_SRC);
            if (!empty[idx] && int'(n) < NUM_WR) begin
                gv[n]    = 1'b1;
                gsrc[n]  = idx;
                pop[idx] = !flush;
                rr_nxt   = SW'((int'(idx) + 1) % NUM_SRC);
                n        = n + GW'(1);
            end
        end
    end

    always_comb begin
        int sum;
        sum = 0;
        for (int i = 0; i < NUM_SRC; i++)
            sum = sum + int'(count[i]) + int'(push[i]) - int'(pop[i]);
        occ_nxt = flush ? '0 : OW'(sum);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            wr_en     <= '0;
            occupancy <= '0;
            stall_cnt <= '0;
            for (int k = 0; k < NUM_WR; k++) begin
                wr_tag[k]  <= '0;
                wr_data[k] <= '0;
            end
        end else begin
            rr_ptr    <= flush ? '0 : rr_nxt;
            occupancy <= occ_nxt;
            if (|(src_valid & ~src_ready) && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            // Tag-0 results are drained but never written.
            for (int k = 0; k < NUM_WR; k++) begin
                wr_en[k] <= gv[k] && !flush && head[gsrc[k]].tag != '0;
                if (gv[k] && !flush) begin
                    wr_tag[k]  <= head[gsrc[k]].tag;
                    wr_data[k] <= head[gsrc[k]].data;
                end
            end
        end
    end

`ifndef SYNTHESIS
    always @(negedge clk) begin
        if (!rst) begin
            for (int a = 0; a < NUM_WR; a++) begin
                assert (!wr_en[a] || wr_tag[a] != '0) else $error("write of tag 0 on port %0d", a);
                for (int b = a + 1; b < NUM_WR; b++)
                    assert (!(wr_en[a] && wr_en[b] && wr_tag[a] == wr_tag[b]))
                        else $error("duplicate tag on ports %0d and %0d", a, b);
            end
        end
    end
`endif
endmodule

// File: doc/superh16_wb_arbiter.md
Name: superh16_wb_arbiter

Overview:
Writeback collector that sits between the execution/load result producers and the physical register file write ports. It accepts completed results from NUM_SRC producers through valid/ready handshakes and buffers them in per-source FIFOs. Each cycle it selects up to NUM_WR results with round-robin fairness and drives the regfile write ports from registers. It is the writer-side counterpart of the regfile, which expects registered, duplicate-free, non-zero-tag writes.

Parameters:
NUM_SRC, 16, number of result producers (ALU, MUL, DIV, LSU pipes)
NUM_WR, 12, regfile write ports (equals ISSUE_WIDTH)
FIFO_DEPTH, 4, entries per source FIFO (power of 2, ≥2)
XLEN, 64, data width (from package)
PHYS_REG_BITS, 10, physical tag width (from package)

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  pipeline flush; discards all buffered results
src_valid[NUM_SRC]  in  1  producer result valid
src_ready[NUM_SRC]  out  1  source FIFO can accept this cycle
src_tag[NUM_SRC]  in  PHYS_REG_BITS  destination physical tag
src_data[NUM_SRC]  in  XLEN  result value
wr_en[NUM_WR]  out  1  regfile write enable (registered)
wr_tag[NUM_WR]  out  PHYS_REG_BITS  regfile write tag (registered)
wr_data[NUM_WR]  out  XLEN  regfile write data (registered)
occupancy  out  $clog2(NUM_SRC*FIFO_DEPTH+1)  total buffered entries (registered)
stall_cnt  out  16  saturating count of cycles with ≥1 src_valid & !src_ready

Behaviour:
- Reset (async, rst=1): all FIFOs empty, rr_ptr=0, wr_en=0, wr_tag=0, wr_data=0, occupancy=0, stall_cnt=0. src_ready follows FIFO state, so it reads 1 during reset. Reset mid-operation drops every buffered entry and in-flight write.
- Accept: a push happens when src_valid[i] & src_ready[i]. src_ready[i] = !full[i], with no same-cycle pop credit. A push into an empty FIFO is not granted in that cycle.
- Arbitration (combinational, each cycle): scan sources cyclically from rr_ptr. Grant non-empty heads in scan order until NUM_WR grants are made. The k-th grant maps to write port k. Granted heads are popped at the edge.
- rr_ptr update: next rr_ptr = (last granted source index + 1) mod NUM_SRC. rr_ptr is unchanged if there are no grants.
- Output register: port k loads the grant's tag/data. wr_en is set only if the grant's tag != 0. A tag-0 entry is popped and silently discarded. Ungranted ports load wr_en=0 and hold their previous tag/data.
- Latency: a result accepted at edge E0 is granted at the earliest in the cycle after E0 and appears on wr_* in the cycle after edge E1 (2 edges minimum).
- Simultaneous push and pop on the same FIFO: both take effect. A full FIFO that is popped still shows src_ready=0 that cycle.
- Flush: at the edge, all FIFOs are emptied, pushes in that cycle are dropped, and grants are cancelled. The next-cycle wr_en is all 0. rr_ptr resets to 0. Writes already registered before the flush edge still appear.
- Pointer arithmetic: FIFO rd/wr pointers are $clog2(FIFO_DEPTH)+1 bits. Full and empty are distinguished by the MSB, and pointers wrap naturally.
- occupancy = sum of FIFO counts after the edge. stall_cnt saturates at 16'hFFFF.
- Simulation assertions:
  - no two wr_en ports carry the same tag in a cycle;
  - no push while full;
  - wr_en implies wr_tag != 0.

Decomposition:
- Package superh16_pkg: XLEN, PHYS_REG_BITS, ISSUE_WIDTH, NUM_WB_SRC, and typedef wb_entry_t {tag, data}.
- Sub-module superh16_wb_fifo: single-source FIFO with push, pop, head, full, empty and count. It is instantiated NUM_SRC times.
- Arbiter scan and output register stay in the top module.

Test Plan:
1. src3 pushes tag=5, data=0xDEAD at edge E0, with no other traffic -> wr_en[0]=1, wr_tag[0]=5, wr_data[0]=0xDEAD in the cycle after E1. All other wr_en are 0. rr_ptr becomes 4.
2. All 16 sources push tags 1..16 in the same cycle, rr_ptr=0 -> the next output cycle writes tags 1..12 on ports 0..11. The following cycle writes tags 13..16 on ports 0..3. rr_ptr ends at 0.
3. All 16 sources assert valid continuously with distinct tags -> FIFOs fill and src_ready drops, stall_cnt increments. Every source gets ≥11 grants per 16 cycles in steady state (fairness). occupancy never exceeds 64.
4. src7 pushes tag=0, data=0x1234 -> the entry is popped, wr_en stays 0 on all ports, and occupancy returns to 0.
5. Buffer 20 entries, then pulse flush -> the next cycle has wr_en all 0 and occupancy=0. A push issued during the flush cycle never appears on wr_*.
6. Assert rst asynchronously mid-burst with occupancy=30 -> wr_en=0 and occupancy=0 immediately, without waiting for a clock edge. After rst deasserts, a new push to src0 tag=9 is written 2 edges later on port 0.
